// File: rtl/expressnet_pkg.sv
// Shared width helpers and types for the expressnet receive path.
// Counter widths are sized so a full buffer's count is representable.
package expressnet_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic overflow;
        logic spurious;
    } err_t;

endpackage

// File: rtl/reg_fifo.sv
// Register-array FIFO with first-word fall-through head.
// A pop frees its slot in the same cycle, so a push into a full FIFO is accepted alongside it.
module reg_fifo
    import expressnet_pkg::*;
#(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [C_DATA_WIDTH-1:0]       wdata,
    input  logic                          pop,
    output logic [C_DATA_WIDTH-1:0]       rdata,
    output logic [cnt_w(C_DEPTH)-1:0]     count,
    output logic                          full,
    output logic                          empty
);

    localparam int CW = cnt_w(C_DEPTH);
    localparam int PW = $clog2(C_DEPTH);

    logic [C_DATA_WIDTH-1:0] mem [C_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (count == CW'(C_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case (1'b1)
                do_push & ~do_pop: count <= count + CW'(1);
                do_pop & ~do_push: count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/srl_credit_sink.sv
// Credit-managed sink behind a fixed-latency delay line: grants issues only
// while stored plus in-flight words leave room, so arrivals always fit.
module srl_credit_sink
    import expressnet_pkg::*;
#(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_LATENCY    = 4,
    parameter int C_DEPTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_req,
    output logic                      issue_ok,
    input  logic                      in_valid,
    input  logic [C_DATA_WIDTH-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [C_DATA_WIDTH-1:0]   out_data,
    output logic [cnt_w(C_DEPTH)-1:0] occupancy,
    output logic [cnt_w(C_DEPTH)-1:0] inflight,
    output logic                      err_overflow,
    output logic                      err_spurious
);

    localparam int CW = cnt_w(C_DEPTH);
    typedef logic [CW-1:0] cnt_t;

    cnt_t        infl_q;
    err_t        err_q;
    logic [CW:0] used;
    logic        issue;
    logic        pop;
    logic        full;
    logic        empty;

    reg_fifo #(
        .C_DATA_WIDTH(C_DATA_WIDTH),
        .C_DEPTH     (C_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (in_valid),
        .wdata(in_data),
        .pop  (pop),
        .rdata(out_data),
        .count(occupancy),
        .full (full),
        .empty(empty)
    );

    // Comparing the sum avoids any wrap if counts were ever corrupted.
    assign used      = {1'b0, occupancy} + {1'b0, infl_q};
    assign issue_ok  = (used < (CW+1)'(C_DEPTH));
    assign issue     = issue_req & issue_ok;
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;

    assign inflight     = infl_q;
    assign err_overflow = err_q.overflow;
    assign err_spurious = err_q.spurious;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            infl_q <= '0;
            err_q  <= '0;
        end else begin
            unique case (1'b1)
                issue & ~in_valid:
                    infl_q <= infl_q + CW'(1);
                in_valid & ~issue & (infl_q != '0):
                    infl_q <= infl_q - CW'(1);
                default: ;
            endcase
            if (in_valid & full & ~pop) err_q.overflow <= 1'b1;
            if (in_valid & (infl_q == '0)) err_q.spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_srl_credit_sink.sv
// Directed bench for srl_credit_sink with a modelled 4-stage delay line.
// A negedge monitor scoreboards popped words and watches stall stability.
module tb_srl_credit_sink;

    logic        clk;
    logic        rst;
    logic        issue_req;
    logic        issue_ok;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  occupancy;
    logic [3:0]  inflight;
    logic        err_overflow;
    logic        err_spurious;

    logic        force_v;
    logic [31:0] force_d;
    logic        srl_v [4];
    logic [31:0] srl_d [4];
    logic [31:0] next_tag = 32'hC000_0000;
    logic [31:0] exp_q [$];

    int total;
    int fails;
    int pops;
    logic        prev_stall;
    logic [31:0] prev_data;

    srl_credit_sink #(
        .C_DATA_WIDTH(32),
        .C_LATENCY   (4),
        .C_DEPTH     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_req   (issue_req),
        .issue_ok    (issue_ok),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .occupancy   (occupancy),
        .inflight    (inflight),
        .err_overflow(err_overflow),
        .err_spurious(err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign in_valid = srl_v[3] | force_v;
    assign in_data  = force_v ? force_d : srl_d[3];

    // Upstream delay line model, reset together with the sink
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) srl_v[i] <= 1'b0;
        end else begin
            srl_v[0] <= issue_req & issue_ok;
            srl_d[0] <= next_tag;
            for (int i = 1; i < 4; i++) begin
                srl_v[i] <= srl_v[i-1];
                srl_d[i] <= srl_d[i-1];
            end
            if (issue_req && issue_ok) begin
                exp_q.push_back(next_tag);
                next_tag <= next_tag + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        #2;
        if (rst) begin
            chk("occ_plus_inflight_le_8",
                {31'd0, (32'(occupancy) + 32'(inflight)) <= 32'd8}, 32'd1);
            if (prev_stall) chk("stall_stable", out_data, prev_data);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    fails++;
                    $error("FAIL unexpected_pop observed=%0h expected=none",
                           out_data);
                end else begin
                    chk("pop_order", out_data, exp_q.pop_front());
                end
                pops++;
            end
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int n;
        total = 0; fails = 0; pops = 0; prev_stall = 1'b0;
        rst = 1'b0; issue_req = 1'b0; out_ready = 1'b0;
        force_v = 1'b0; force_d = '0;
        step(); step();
        chk("rst_issue_ok", {31'd0, issue_ok}, 1);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_occ", {28'd0, occupancy}, 0);
        chk("rst_inflight", {28'd0, inflight}, 0);
        chk("rst_errs", {30'd0, err_overflow, err_spurious}, 0);
        rst = 1'b1;
        step();

        // 1: streaming, first arrival visible after the 5th edge
        issue_req = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i <= 4) chk("t1_no_valid_yet", {31'd0, out_valid}, 0);
            if (i == 5) chk("t1_valid_rises", {31'd0, out_valid}, 1);
            chk("t1_issue_ok", {31'd0, issue_ok}, 1);
            chk("t1_occ_le_1", {31'd0, occupancy <= 4'd1}, 1);
        end
        issue_req = 1'b0;
        for (int i = 0; i < 60 && (out_valid || inflight != 0); i++) step();
        chk("t1_pops", pops, 20);

        // 2: stalled consumer, credits exhaust at 8
        issue_req = 1'b1; out_ready = 1'b0; n = 0;
        for (int i = 0; i < 20; i++) begin
            if (issue_ok) n++;
            step();
        end
        chk("t2_grants", n, 8);
        chk("t2_issue_ok_low", {31'd0, issue_ok}, 0);
        chk("t2_occ_full", {28'd0, occupancy}, 8);
        chk("t2_inflight", {28'd0, inflight}, 0);
        chk("t2_no_overflow", {31'd0, err_overflow}, 0);
        issue_req = 1'b0; out_ready = 1'b1;
        step();
        chk("t2_credit_back", {31'd0, issue_ok}, 1);
        for (int i = 0; i < 60 && (out_valid || inflight != 0); i++) step();
        chk("t2_pops", pops, 28);

        // 4: full FIFO, arrival and pop together are absorbed
        issue_req = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 20; i++) step();
        issue_req = 1'b0;
        chk("t4_full", {28'd0, occupancy}, 8);
        force_v = 1'b1; force_d = 32'h0000_1234; out_ready = 1'b1;
        exp_q.push_back(32'h0000_1234);
        step();
        force_v = 1'b0; out_ready = 1'b0;
        chk("t4_occ_stays", {28'd0, occupancy}, 8);
        chk("t4_no_overflow", {31'd0, err_overflow}, 0);
        chk("t4_spurious", {31'd0, err_spurious}, 1);
        chk("t4_inflight_sat", {28'd0, inflight}, 0);

        // 3: arrival into a full FIFO is dropped
        force_v = 1'b1; force_d = 32'h0000_DEAD;
        step();
        force_v = 1'b0;
        chk("t3_overflow", {31'd0, err_overflow}, 1);
        chk("t3_spurious", {31'd0, err_spurious}, 1);
        chk("t3_occ", {28'd0, occupancy}, 8);
        out_ready = 1'b1;
        for (int i = 0; i < 60 && out_valid; i++) step();
        chk("t3_pops", pops, 37);
        chk("t3_q_empty", exp_q.size(), 0);

        // 5: asynchronous reset with 5 stored and 3 in flight
        out_ready = 1'b0; issue_req = 1'b1;
        for (int i = 0; i < 8; i++) step();
        issue_req = 1'b0;
        step();
        chk("t5_occ_pre", {28'd0, occupancy}, 5);
        chk("t5_inflight_pre", {28'd0, inflight}, 3);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        exp_q.delete();
        chk("t5_async_occ", {28'd0, occupancy}, 0);
        chk("t5_async_inflight", {28'd0, inflight}, 0);
        chk("t5_async_valid", {31'd0, out_valid}, 0);
        chk("t5_async_issue_ok", {31'd0, issue_ok}, 1);
        chk("t5_async_errs", {30'd0, err_overflow, err_spurious}, 0);
        step(); step();
        rst = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_no_stale", {31'd0, out_valid}, 0);
        end
        chk("t5_no_spurious", {31'd0, err_spurious}, 0);
        chk("t5_issue_ok", {31'd0, issue_ok}, 1);

        // 6: random backpressure over 1000 issues
        issue_req = 1'b1; n = 0;
        for (int i = 0; i < 20000 && n < 1000; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (issue_ok) n++;
            step();
        end
        issue_req = 1'b0;
        chk("t6_issues", n, 1000);
        out_ready = 1'b1;
        for (int i = 0; i < 60 && (out_valid || inflight != 0); i++) step();
        chk("t6_pops", pops, 1037);
        chk("t6_q_empty", exp_q.size(), 0);
        chk("t6_no_errs", {30'd0, err_overflow, err_spurious}, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
